// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter of 2*CPUS cache ports (even r = data, odd r = instruction) onto one RAM port; 1-cycle grant latency, ramstate-driven stall.
// Optional MEMCTL_DATA_PRIORITY_EN: in IDLE, pending data requests exclude instruction ports from the search.
module memory_arbiter_rr #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);
  localparam int N  = 2 * CPUS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
`ifdef MEMCTL_DATA_PRIORITY_EN
  localparam logic [N-1:0] DATA_MASK = {CPUS{2'b01}};
`endif

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_gnt, w_gnt_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic [N-1:0]    w_req, w_search;
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_idx;

  logic            w_g_dren, w_g_dwen, w_g_iren;
  logic [ADDR_W-1:0] w_g_daddr, w_g_iaddr;
  logic [WORD_W-1:0] w_g_dstore;
  logic            w_g_is_d, w_g_live, w_active, w_done;

  always_comb begin
    w_req = '0;
    for (int c = 0; c < CPUS; c++) begin
      w_req[2*c]   = dREN[c] | dWEN[c];
      w_req[2*c+1] = iREN[c];
    end
  end

  // Walk from rr_ptr downward in k so the closest active requester is the last to overwrite w_pick.
  always_comb begin
    w_search = w_req;
`ifdef MEMCTL_DATA_PRIORITY_EN
    if (|(w_req & DATA_MASK)) w_search = w_req & DATA_MASK;
`endif
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (w_search[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_g_dren   = 1'b0;
    w_g_dwen   = 1'b0;
    w_g_iren   = 1'b0;
    w_g_daddr  = '0;
    w_g_iaddr  = '0;
    w_g_dstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if ((r_gnt >> 1) == PW'(c)) begin
        w_g_dren   = dREN[c];
        w_g_dwen   = dWEN[c];
        w_g_iren   = iREN[c];
        w_g_daddr  = daddr[c*ADDR_W +: ADDR_W];
        w_g_iaddr  = iaddr[c*ADDR_W +: ADDR_W];
        w_g_dstore = dstore[c*WORD_W +: WORD_W];
      end
    end
  end

  assign w_g_is_d = ~r_gnt[0];
  assign w_g_live = w_g_is_d ? (w_g_dren | w_g_dwen) : w_g_iren;
  assign w_active = (r_state == GRANT) && w_g_live;
  assign w_done   = w_active && (ramstate == RAM_ACCESS);

  // RAM side follows the granted port's live signals, so a withdrawn request drops the enables at once.
  always_comb begin
    ramWEN   = w_active && w_g_is_d && w_g_dwen;
    ramREN   = w_active && !(w_g_is_d && w_g_dwen);
    ramaddr  = '0;
    ramstore = '0;
    if (w_active) ramaddr = w_g_is_d ? w_g_daddr : w_g_iaddr;
    if (ramWEN) ramstore = w_g_dstore;
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (w_done && ((r_gnt >> 1) == PW'(c))) begin
        if (w_g_is_d) begin
          dwait[c] = 1'b0;
          dload[c*WORD_W +: WORD_W] = w_g_dwen ? '0 : ramload;
        end else begin
          iwait[c] = 1'b0;
          iload[c*WORD_W +: WORD_W] = ramload;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick;
        end
      end
      GRANT: begin
        if (!w_g_live) begin
          w_state_nxt = IDLE;
        end else if (w_done) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = (r_gnt == PW'(N-1)) ? '0 : r_gnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end
endmodule
